// File: rtl/cdma_wg_entry_expander.sv
// WG entry expander: pops one FIFO entry (eop + beats_m1) and emits
// eff_m1+1 indexed beats, clamping oversized entries to cfg_beat_max.
// Counts completed eop groups and flags any clamped entry.
module cdma_wg_entry_expander #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  output logic             in_ready,
  input  logic [4:0]       in_data,
  input  logic [3:0]       cfg_beat_max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_beat_idx,
  output logic             out_beat_last,
  output logic             out_group_last,
  output logic [CNT_W-1:0] grp_cnt,
  output logic             clamp_err,
  output logic             idle
);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       beat_idx_q;
  logic [3:0]       eff_m1_q;
  logic             eop_q;
  logic [CNT_W-1:0] grp_cnt_q;
  logic             clamp_q;

  logic             accept;
  logic             beat_hs;
  logic             over_max;
  logic [3:0]       eff_m1_new;

  assign out_valid      = (state_q == EXPAND);
  assign out_beat_idx   = beat_idx_q;
  assign out_beat_last  = (beat_idx_q == eff_m1_q);
  assign out_group_last = out_beat_last && eop_q;
  assign grp_cnt        = grp_cnt_q;
  assign clamp_err      = clamp_q;
  assign idle           = (state_q == IDLE);

  // Ready when empty, or when the final beat leaves this cycle so the next
  // entry can be loaded with no bubble.
  assign in_ready   = (state_q == IDLE) || (out_valid && out_ready && out_beat_last);
  assign accept     = in_req && in_ready;
  assign beat_hs    = out_valid && out_ready;
  assign over_max   = (in_data[3:0] > cfg_beat_max);
  assign eff_m1_new = over_max ? cfg_beat_max : in_data[3:0];

  // Next-state: enter EXPAND on accept, leave only on an unreplaced last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EXPAND;
      end
      EXPAND: begin
        if (beat_hs && out_beat_last) state_d = accept ? EXPAND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Entry latch, beat counter, group counter and sticky clamp flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx_q <= '0;
      eff_m1_q   <= '0;
      eop_q      <= 1'b0;
      grp_cnt_q  <= '0;
      clamp_q    <= 1'b0;
    end else begin
      if (accept) begin
        eff_m1_q   <= eff_m1_new;
        eop_q      <= in_data[4];
        beat_idx_q <= '0;
      end else if (beat_hs && !out_beat_last) begin
        beat_idx_q <= beat_idx_q + 4'd1;
      end
      if (beat_hs && out_group_last) grp_cnt_q <= grp_cnt_q + CNT_W'(1);
      if (accept && over_max)        clamp_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdma_wg_entry_expander.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// each cycle against a queue-of-beats reference model.
module tb_cdma_wg_entry_expander;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             in_req;
  logic             in_ready;
  logic [4:0]       in_data;
  logic [3:0]       cfg_beat_max;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_beat_idx;
  logic             out_beat_last;
  logic             out_group_last;
  logic [CNT_W-1:0] grp_cnt;
  logic             clamp_err;
  logic             idle;

  cdma_wg_entry_expander #(.CNT_W(CNT_W)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .in_req         (in_req),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .cfg_beat_max   (cfg_beat_max),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_beat_idx   (out_beat_idx),
    .out_beat_last  (out_beat_last),
    .out_group_last (out_group_last),
    .grp_cnt        (grp_cnt),
    .clamp_err      (clamp_err),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every accepted entry expands into a list of beats.
  typedef struct {
    int unsigned idx;
    bit          last;
    bit          glast;
  } beat_t;

  beat_t       m_q[$];
  int unsigned m_grp;
  bit          m_clamp;

  int unsigned n_vec;
  int unsigned n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs, advance the model across the edge.
  task automatic step(input bit rst, input bit req, input logic [4:0] data,
                      input logic [3:0] cfg, input bit ordy);
    bit          m_valid;
    bit          m_ready;
    bit          head_last;
    int unsigned m1;
    int unsigned eff;
    reset        = rst;
    in_req       = req;
    in_data      = data;
    cfg_beat_max = cfg;
    out_ready    = ordy;
    #2;
    m_valid   = (m_q.size() != 0);
    head_last = m_valid && m_q[0].last;
    m_ready   = !m_valid || (head_last && ordy);
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    check_val("idle",      32'(idle),      32'(!m_valid));
    check_val("in_ready",  32'(in_ready),  32'(m_ready));
    check_val("grp_cnt",   32'(grp_cnt),   m_grp % (1 << CNT_W));
    check_val("clamp_err", 32'(clamp_err), 32'(m_clamp));
    if (m_valid) begin
      check_val("beat_idx",   32'(out_beat_idx),   m_q[0].idx);
      check_val("beat_last",  32'(out_beat_last),  32'(m_q[0].last));
      check_val("group_last", 32'(out_group_last), 32'(m_q[0].glast));
    end
    if (rst) begin
      m_q.delete();
      m_grp   = 0;
      m_clamp = 0;
    end else begin
      if (m_valid && ordy) begin
        if (m_q[0].glast) m_grp++;
        void'(m_q.pop_front());
      end
      if (req && m_ready) begin
        m1  = data[3:0];
        eff = (m1 < cfg) ? m1 : cfg;
        if (m1 > cfg) m_clamp = 1;
        for (int unsigned i = 0; i <= eff; i++) begin
          beat_t b;
          b.idx   = i;
          b.last  = (i == eff);
          b.glast = (i == eff) && data[4];
          m_q.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int unsigned n, input logic [3:0] cfg);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 5'h00, cfg, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_grp = 0;
    m_clamp = 0;
    reset = 1'b1;
    in_req = 1'b0;
    in_data = '0;
    cfg_beat_max = 4'hF;
    out_ready = 1'b1;
    // Establish a known state before any checking.
    @(posedge clk);
    @(posedge clk);
    #1;
    step(1, 0, 5'h00, 4'hF, 1);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // Single entry 0x13: four beats, group_last on idx 3.
    step(0, 1, 5'h13, 4'hF, 1);
    idle_cycles(5, 4'hF);
    check_val("s1_grp", 32'(grp_cnt), 32'd1);

    // Back-to-back 0x01 then 0x10 with in_req held.
    step(0, 1, 5'h01, 4'hF, 1);
    step(0, 1, 5'h10, 4'hF, 1);
    step(0, 1, 5'h10, 4'hF, 1);
    step(0, 0, 5'h00, 4'hF, 1);
    idle_cycles(2, 4'hF);

    // Clamped entry 0x07 with cfg=2.
    step(0, 1, 5'h07, 4'h2, 1);
    idle_cycles(5, 4'h2);
    check_val("s3_clamp_sticky", 32'(clamp_err), 32'd1);

    // Stalls on entry 0x02: out_ready 1,0,0,1,...
    step(1, 0, 5'h00, 4'hF, 1);
    step(0, 1, 5'h02, 4'hF, 1);
    step(0, 0, 5'h00, 4'hF, 1);
    step(0, 0, 5'h00, 4'hF, 0);
    step(0, 0, 5'h00, 4'hF, 0);
    step(0, 0, 5'h00, 4'hF, 1);
    idle_cycles(3, 4'hF);

    // Reset during idx 1 of entry 0x15, then single-beat 0x10.
    step(0, 1, 5'h15, 4'hF, 1);
    step(0, 0, 5'h00, 4'hF, 1);
    step(1, 0, 5'h00, 4'hF, 1);
    check_val("s5_valid_after_rst", 32'(out_valid), 32'd0);
    step(0, 1, 5'h10, 4'hF, 1);
    idle_cycles(3, 4'hF);

    // 256 single-beat eop entries wrap the group counter.
    step(1, 0, 5'h00, 4'hF, 1);
    for (int unsigned i = 0; i < 256; i++) step(0, 1, 5'h10, 4'hF, 1);
    step(0, 0, 5'h00, 4'hF, 1);
    check_val("s6_grp_wrap", 32'(grp_cnt), 32'd0);
    idle_cycles(2, 4'hF);

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      bit         r_rst;
      bit         r_req;
      bit         r_ordy;
      logic [4:0] r_data;
      logic [3:0] r_cfg;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_req  = ($urandom_range(0, 9) < 7);
      r_ordy = ($urandom_range(0, 9) < 7);
      r_data = 5'($urandom);
      r_cfg  = (i % 400 < 200) ? 4'hF : 4'(i / 400 + 3);
      step(r_rst, r_req, r_data, r_cfg, r_ordy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
